// File: rtl/scan_capture_pkg.sv
// Shared encodings for the scan capture controller: FSM states and photo strobe codes.
package scan_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOT = 2'd1,
    ST_TASK = 2'd2
  } state_e;

  localparam logic [1:0] PHOTO_NONE = 2'b00;
  localparam logic [1:0] PHOTO_REF  = 2'b10;
  localparam logic [1:0] PHOTO_MEAS = 2'b01;

endpackage

// File: rtl/onehot_mode_enc.sv
// One-hot mode select to 1-based index; any pattern that is not exactly one-hot decodes to 0.
module onehot_mode_enc
  import scan_capture_pkg::*;
#(
  parameter int N_MODE = 7,
  parameter int IDX_W  = $clog2(N_MODE + 1)
) (
  input  logic [N_MODE-1:0] onehot,
  output logic [IDX_W-1:0]  idx
);

  logic             found_s;
  logic             multi_s;
  logic [IDX_W-1:0] pos_s;

  // scan all lines, remembering the last set bit and whether more than one was set
  always_comb begin
    found_s = 1'b0;
    multi_s = 1'b0;
    pos_s   = {IDX_W{1'b0}};
    for (int i = 0; i < N_MODE; i++) begin
      multi_s = multi_s | (found_s & onehot[i]);
      found_s = found_s | onehot[i];
      pos_s   = onehot[i] ? IDX_W'(i + 1) : pos_s;
    end
  end

  assign idx = (found_s && !multi_s) ? pos_s : {IDX_W{1'b0}};

endmodule

// File: rtl/scan_capture_ctrl.sv
// Scan capture sequencer: angle register, auto-rotate accumulator and the
// reference/measurement photo sequence handed to a downstream engine.
module scan_capture_ctrl
  import scan_capture_pkg::*;
#(
  parameter int N_MODE   = 7,
  parameter int DEG_W    = 6,
  parameter int DEG_INIT = 6,
  parameter int DEG_MIN  = 0,
  parameter int DEG_MAX  = 63,
  parameter int SAT      = 1,
  parameter int TICK_W   = 26,
  parameter int HOLD_CYC = 2**25,
  parameter int BURST    = 1,
  localparam int MODE_W  = $clog2(N_MODE + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_MODE-1:0] i_mode,
  input  logic              i_setup,
  input  logic              i_degplus,
  input  logic              i_degsub,
  input  logic [2:0]        i_rotate,
  input  logic              i_busy,
  input  logic              i_abort,
  output logic [DEG_W-1:0]  o_deg,
  output logic [MODE_W-1:0] o_mode,
  output logic [1:0]        o_takephoto,
  output logic              o_newtask,
  output logic [3:0]        o_shots_left,
  output logic [1:0]        o_state
);

  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_e              state_r, state_s;
  logic [DEG_W-1:0]    deg_r, deg_s;
  logic [MODE_W-1:0]   mode_r, mode_s;
  logic [1:0]          photo_r, photo_s;
  logic                newtask_r, newtask_s;
  logic [3:0]          shots_r, shots_s;
  logic                pend_r, pend_s;
  logic [HOLD_W-1:0]   hold_r, hold_s;
  logic [TICK_W-1:0]   acc_r, acc_s;
  logic [TICK_W-1:0]   acc_sum_s;
  logic                tick_s;
  logic                mode_on_s;
  logic                step_s;
  logic [MODE_W-1:0]   dec_mode_s;

  function automatic logic [DEG_W-1:0] deg_up(input logic [DEG_W-1:0] d);
    logic [DEG_W-1:0] r;
    if ((SAT != 0) && (d == DEG_W'(DEG_MAX))) r = DEG_W'(DEG_MAX);
    else                                      r = d + DEG_W'(1);
    return r;
  endfunction

  function automatic logic [DEG_W-1:0] deg_dn(input logic [DEG_W-1:0] d);
    logic [DEG_W-1:0] r;
    if ((SAT != 0) && (d == DEG_W'(DEG_MIN))) r = DEG_W'(DEG_MIN);
    else                                      r = d - DEG_W'(1);
    return r;
  endfunction

  onehot_mode_enc #(
    .N_MODE (N_MODE),
    .IDX_W  (MODE_W)
  ) u_mode_enc (
    .onehot (i_mode),
    .idx    (dec_mode_s)
  );

  assign acc_sum_s = acc_r + TICK_W'(i_rotate);
  assign tick_s    = acc_sum_s[TICK_W-1];
  assign mode_on_s = (mode_r != {MODE_W{1'b0}});
  assign step_s    = i_degplus ^ i_degsub;

  // next-state and next-output logic; abort overrides every state
  always_comb begin
    state_s   = state_r;
    deg_s     = deg_r;
    mode_s    = mode_r;
    photo_s   = photo_r;
    newtask_s = 1'b0;
    shots_s   = shots_r;
    pend_s    = pend_r;
    hold_s    = hold_r;
    acc_s     = acc_r;
    if (i_abort) begin
      state_s = ST_IDLE;
      photo_s = PHOTO_NONE;
      pend_s  = 1'b0;
      shots_s = 4'd0;
      hold_s  = {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          acc_s = tick_s ? {TICK_W{1'b0}} : acc_sum_s;
          if (i_setup) begin
            if (dec_mode_s != {MODE_W{1'b0}}) begin
              mode_s  = dec_mode_s;
              deg_s   = DEG_W'(DEG_INIT);
              shots_s = 4'(BURST);
              pend_s  = 1'b0;
              hold_s  = {HOLD_W{1'b0}};
              photo_s = PHOTO_REF;
              state_s = ST_SHOT;
            end else if (mode_on_s) begin
              mode_s    = {MODE_W{1'b0}};
              deg_s     = DEG_W'(DEG_INIT);
              newtask_s = 1'b1;
              state_s   = ST_TASK;
            end else begin
              state_s = ST_IDLE;
            end
          end else if (step_s && mode_on_s) begin
            deg_s     = i_degplus ? deg_up(deg_r) : deg_dn(deg_r);
            newtask_s = 1'b1;
            state_s   = ST_TASK;
          end else if (tick_s && mode_on_s) begin
            deg_s     = deg_up(deg_r);
            newtask_s = 1'b1;
            state_s   = ST_TASK;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SHOT: begin
          if (hold_r == HOLD_LAST) begin
            hold_s  = {HOLD_W{1'b0}};
            photo_s = PHOTO_NONE;
            if (photo_r == PHOTO_REF) begin
              pend_s    = 1'b1;
              newtask_s = 1'b1;
              state_s   = ST_TASK;
            end else if (shots_r != 4'd1) begin
              shots_s   = shots_r - 4'd1;
              deg_s     = deg_up(deg_r);
              pend_s    = 1'b1;
              newtask_s = 1'b1;
              state_s   = ST_TASK;
            end else begin
              shots_s = 4'd0;
              pend_s  = 1'b0;
              state_s = ST_IDLE;
            end
          end else begin
            hold_s = hold_r + HOLD_W'(1);
          end
        end
        ST_TASK: begin
          if (!i_busy) begin
            if (pend_r) begin
              pend_s  = 1'b0;
              hold_s  = {HOLD_W{1'b0}};
              photo_s = PHOTO_MEAS;
              state_s = ST_SHOT;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_TASK;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // state and output registers; reset parks in TASK so the first idle engine cycle releases to IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_TASK;
      deg_r     <= DEG_W'(DEG_INIT);
      mode_r    <= {MODE_W{1'b0}};
      photo_r   <= PHOTO_NONE;
      newtask_r <= 1'b0;
      shots_r   <= 4'd0;
      pend_r    <= 1'b0;
      hold_r    <= {HOLD_W{1'b0}};
      acc_r     <= {TICK_W{1'b0}};
    end else begin
      state_r   <= state_s;
      deg_r     <= deg_s;
      mode_r    <= mode_s;
      photo_r   <= photo_s;
      newtask_r <= newtask_s;
      shots_r   <= shots_s;
      pend_r    <= pend_s;
      hold_r    <= hold_s;
      acc_r     <= acc_s;
    end
  end

  assign o_deg        = deg_r;
  assign o_mode       = mode_r;
  assign o_takephoto  = photo_r;
  assign o_newtask    = newtask_r;
  assign o_shots_left = shots_r;
  assign o_state      = state_r;

endmodule
